// File: rtl/control_unit.sv
// ID-stage decoder for the LW/SW/ADD/SUB/MUL subset; the registered Ctrl word is the ID/EX control register.
// Optional CTRL_ILLEGAL_FLAG_EN drives Ctrl[15] high for illegal encodings; when it is undefined, Ctrl[15] is always 0.
module control_unit #(
  parameter logic [5:0] OP_LW    = 6'b000100,
  parameter logic [5:0] OP_SW    = 6'b000101,
  parameter logic [5:0] OP_RTYPE = 6'b000011,
  parameter logic [5:0] FN_ADD   = 6'b100000,
  parameter logic [5:0] FN_SUB   = 6'b100010,
  parameter logic [5:0] FN_MUL   = 6'b110010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction,
  output logic [23:0] Ctrl
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  dest;

  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_write;
  logic        mem_read;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        reg_dst;
  logic        illegal;
  logic        ill_bit;
  logic [23:0] ctrl_next;
  logic        unused_ok;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign funct  = Instruction[5:0];

  always_comb begin
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        mem_read   = 1'b1;
        alu_src    = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            alu_op    = ALU_ADD;
          end
          FN_SUB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            alu_op    = ALU_SUB;
          end
          FN_MUL: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            alu_op    = ALU_MUL;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal encodings keep all write/enable bits low, so they flow down the pipe as a NOP.
  assign dest = reg_dst ? rd : rt;

`ifdef CTRL_ILLEGAL_FLAG_EN
  assign ill_bit   = illegal;
  assign unused_ok = ^Instruction[10:6];
`else
  assign ill_bit   = 1'b0;
  assign unused_ok = ^{Instruction[10:6], illegal};
`endif

  assign ctrl_next = {reg_write, mem_to_reg, mem_write, mem_read, alu_src,
                      alu_op, reg_dst, ill_bit, dest, rs, rt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Ctrl <= 24'h000000;
    else        Ctrl <= ctrl_next;
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a field-level reference model is compared every cycle, with literal vectors and randomized
// instructions/async resets as stimulus.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instruction;
  logic [23:0] Ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [23:0] exp_ctrl = 24'h0;

  control_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .Instruction(Instruction),
    .Ctrl(Ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CTRL_ILLEGAL_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  // Reference: look up the control byte by instruction kind, then assemble the fields arithmetically.
  function automatic logic [23:0] model(input logic [31:0] ins);
    int op, fn, rs, rt, rd, hi, ill, dst;
    op = int'(ins[31:26]); fn = int'(ins[5:0]);
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    ill = 0; dst = rt;
    if (op == 4)      hi = 'hD8;
    else if (op == 5) hi = 'h28;
    else if (op == 3 && fn == 'h20) begin hi = 'h81; dst = rd; end
    else if (op == 3 && fn == 'h22) begin hi = 'h83; dst = rd; end
    else if (op == 3 && fn == 'h32) begin hi = 'h85; dst = rd; end
    else begin hi = 0; ill = FLAG_EN ? 1 : 0; end
    return 24'(hi * 65536 + ill * 32768 + dst * 1024 + rs * 32 + rt);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_ctrl <= 24'h0;
    else        exp_ctrl <= model(Instruction);
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) check("cycle", Ctrl, exp_ctrl);

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b000011, 5'(rs), 5'(rt), 5'(rd), 5'd10, fn};
  endfunction

  task automatic drive_and_check(input string name, input logic [31:0] ins, input logic [23:0] lit);
    Instruction = ins;
    @(negedge clk); #1;
    check(name, Ctrl, lit);
  endtask

  initial begin
    logic [31:0] ins;
    logic [23:0] ill_lit;
    rst_n = 1'b1;
    Instruction = 32'h0;
    #2 rst_n = 1'b0;
    #1 check("reset_async", Ctrl, 24'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("reset_hold", Ctrl, 24'h0);
    chk_en = 1'b1;
    @(negedge clk); #1;

    // Literal vectors, one per cycle.
    drive_and_check("lw",  {6'b000100, 5'd0, 5'd1, 16'b0000111100000000}, 24'hD80401);
    drive_and_check("sw",  {6'b000101, 5'd0, 5'd1, 16'h0000}, 24'h280401);
    drive_and_check("mul", rtype(1, 2, 5, 6'b110010), 24'h851422);
    drive_and_check("add", rtype(3, 4, 6, 6'b100000), 24'h811864);
    drive_and_check("sub", rtype(5, 6, 7, 6'b100010), 24'h831CA6);
    ill_lit = FLAG_EN ? 24'h008401 : 24'h000401;
    drive_and_check("ill_op", {6'b111111, 5'd0, 5'd1, 5'd2, 11'd0}, ill_lit);
    Instruction = rtype(9, 10, 11, 6'b000000);
    @(negedge clk); #1;
    check("ill_funct_hi", {16'h0, Ctrl[23:16]}, 24'h0);

    // Mid-cycle async reset with an instruction pending.
    Instruction = {6'b000100, 5'd3, 5'd4, 16'h1234};
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("reset_mid", Ctrl, 24'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 check("reset_release", Ctrl, 24'hD81064);

    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      case ($urandom_range(0, 4))
        0: ins = {6'b000100, 26'($urandom)};
        1: ins = {6'b000101, 26'($urandom)};
        2: ins = {6'($urandom), 26'($urandom)};
        default: begin
          ins = {6'b000011, 26'($urandom)};
          case ($urandom_range(0, 3))
            0: ins[5:0] = 6'b100000;
            1: ins[5:0] = 6'b100010;
            2: ins[5:0] = 6'b110010;
            default: ;
          endcase
        end
      endcase
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1 check("rand_reset", Ctrl, 24'h0);
        #1 rst_n = 1'b1;
      end
      Instruction = ins;
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
